// File: rtl/serial_transfer_unit_if.sv
// Bundle of the controller-facing handshake and data signals for serial_transfer_unit.
// master: controller side (drives SampleData/TransferData/Mode/MemData/ExtData).
// slave : serial unit side (drives SerialOut/SerialClk/SerialValid/TransferDone).
interface serial_transfer_unit_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  SampleData;
  logic                  TransferData;
  logic                  Mode;
  logic [DATA_WIDTH-1:0] MemData;
  logic [DATA_WIDTH-1:0] ExtData;
  logic                  SerialOut;
  logic                  SerialClk;
  logic                  SerialValid;
  logic                  TransferDone;

  modport master (
    output SampleData, TransferData, Mode, MemData, ExtData,
    input  SerialOut, SerialClk, SerialValid, TransferDone
  );

  modport slave (
    input  SampleData, TransferData, Mode, MemData, ExtData,
    output SerialOut, SerialClk, SerialValid, TransferDone
  );
endinterface

// File: rtl/serial_transfer_unit.sv
// Captures a word (MemData when Mode=1, else ExtData) on SampleData and shifts it out MSB-first.
// Latency: first bit visible right after the capture edge; CLK_DIV Clk cycles per bit; TransferDone after DATA_WIDTH*CLK_DIV edges.
// Backpressure: TransferData low aborts a transfer; TransferDone is held while SampleData stays high.
// Ports: Clk, Reset (async, active-high), Bus (serial_transfer_unit_if.slave).
module serial_transfer_unit #(
  parameter int DATA_WIDTH = 8,
  parameter int CLK_DIV    = 4
) (
  input  logic                  Clk,
  input  logic                  Reset,
  serial_transfer_unit_if.slave Bus
);

  localparam int BitW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam int DivW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [BitW-1:0] LastBit = BitW'(DATA_WIDTH - 1);
  localparam logic [DivW-1:0] LastDiv = DivW'(CLK_DIV - 1);
  localparam logic [DivW-1:0] HalfDiv = DivW'(CLK_DIV / 2);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t                state, stateNext;
  logic [DATA_WIDTH-1:0] shiftReg, shiftNext;
  logic [BitW-1:0]       bitCnt, bitCntNext;
  logic [DivW-1:0]       divCnt, divCntNext;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state    <= IDLE;
      shiftReg <= '0;
      bitCnt   <= '0;
      divCnt   <= '0;
    end else begin
      state    <= stateNext;
      shiftReg <= shiftNext;
      bitCnt   <= bitCntNext;
      divCnt   <= divCntNext;
    end
  end

  always_comb begin
    stateNext  = state;
    shiftNext  = shiftReg;
    bitCntNext = bitCnt;
    divCntNext = divCnt;
    case (state)
      IDLE: begin
        if (Bus.SampleData) begin
          shiftNext  = Bus.Mode ? Bus.MemData : Bus.ExtData;
          bitCntNext = '0;
          divCntNext = '0;
          stateNext  = SHIFT;
        end
      end
      SHIFT: begin
        // Abort wins over the bit advance; counters are re-cleared on the next capture.
        if (!Bus.TransferData) begin
          stateNext = IDLE;
        end else if (divCnt == LastDiv) begin
          divCntNext = '0;
          if (bitCnt == LastBit) begin
            stateNext = DONE;
          end else begin
            shiftNext  = shiftReg << 1;
            bitCntNext = bitCnt + BitW'(1);
          end
        end else begin
          divCntNext = divCnt + DivW'(1);
        end
      end
      DONE: begin
        // Holding here while SampleData is high keeps the controller from retriggering.
        if (!Bus.SampleData) begin
          stateNext = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  // Outputs decode registered state only, so reset clears them immediately.
  assign Bus.SerialValid  = (state == SHIFT);
  assign Bus.SerialOut    = (state == SHIFT) && shiftReg[DATA_WIDTH-1];
  assign Bus.SerialClk    = (state == SHIFT) && (divCnt >= HalfDiv);
  assign Bus.TransferDone = (state == DONE);

endmodule
